// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: control path of the five-stage ARM-subset core.
// Decodes the D-stage instruction, carries the control word through the
// E/M/W pipeline registers, evaluates the condition field in E against the
// internal NZCV register and gates every architectural write with it.
// Build option: define COND_EXEC_EN for full condition evaluation; without it
// every instruction executes unconditionally (flags are still tracked).
module ctrl_pipe_unit #(
    parameter int ALUCTRL_W  = 2,
    parameter bit CMP_EN_CMD = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          InstrD,
    input  logic                 FlushE,
    input  logic [3:0]           ALUFlagsE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic [1:0]           ImmSrcD,
    output logic [1:0]           RegSrcD,
    output logic                 BranchTakenE,
    output logic                 PCSrcW,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
    output logic                 MemWriteM,
    output logic                 MemtoRegE,
    output logic                 MemtoRegW
);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_EOR = ALUCTRL_W'(4);
    localparam logic [3:0]           COND_AL = 4'hE;

    logic [1:0] op_d;
    logic [3:0] cmd_d, rd_d;
    logic       s_d, i_d, l_d, dp_ok;

    assign op_d = InstrD[27:26];
    assign i_d  = InstrD[25];
    assign cmd_d = InstrD[24:21];
    assign s_d  = InstrD[20];
    assign l_d  = InstrD[20];
    assign rd_d = InstrD[15:12];

    logic                 unused_instr;
    assign unused_instr = ^{InstrD[19:16], InstrD[11:0]};

    logic [ALUCTRL_W-1:0] alu_d;
    logic                 alusrc_d, regw_d, memw_d, memtoreg_d, branch_d, pcs_d;
    logic [1:0]           flagw_d;

    // D-stage decode; anything unsupported falls through as a NOP with no writes.
    always_comb begin
        alu_d      = '0;
        alusrc_d   = 1'b0;
        regw_d     = 1'b0;
        memw_d     = 1'b0;
        memtoreg_d = 1'b0;
        branch_d   = 1'b0;
        flagw_d    = 2'b00;
        ImmSrcD    = 2'b00;
        RegSrcD    = 2'b00;
        dp_ok      = 1'b0;
        case (op_d)
            2'b00: begin
                dp_ok = 1'b1;
                case (cmd_d)
                    4'b0100: begin alu_d = ALU_ADD; regw_d = 1'b1; flagw_d = {s_d, s_d}; end
                    4'b0010: begin alu_d = ALU_SUB; regw_d = 1'b1; flagw_d = {s_d, s_d}; end
                    4'b0000: begin alu_d = ALU_AND; regw_d = 1'b1; flagw_d = {s_d, 1'b0}; end
                    4'b1100: begin alu_d = ALU_ORR; regw_d = 1'b1; flagw_d = {s_d, 1'b0}; end
                    4'b0001: begin
                        if (ALUCTRL_W >= 3) begin
                            alu_d   = ALU_EOR;
                            regw_d  = 1'b1;
                            flagw_d = {s_d, 1'b0};
                        end else begin
                            dp_ok = 1'b0;
                        end
                    end
                    4'b1010: begin
                        if (CMP_EN_CMD && s_d) begin
                            alu_d   = ALU_SUB;
                            flagw_d = 2'b11;
                        end else begin
                            dp_ok = 1'b0;
                        end
                    end
                    default: dp_ok = 1'b0;
                endcase
                alusrc_d = dp_ok & i_d;
            end
            2'b01: begin
                ImmSrcD    = 2'b01;
                RegSrcD    = {~l_d, 1'b0};
                alusrc_d   = 1'b1;
                alu_d      = ALU_ADD;
                regw_d     = l_d;
                memtoreg_d = l_d;
                memw_d     = ~l_d;
            end
            2'b10: begin
                ImmSrcD  = 2'b10;
                RegSrcD  = 2'b01;
                alusrc_d = 1'b1;
                alu_d    = ALU_ADD;
                branch_d = 1'b1;
            end
            default: ;
        endcase
        pcs_d = ((rd_d == 4'hF) && regw_d) || branch_d;
    end

    logic [ALUCTRL_W-1:0] alu_e_q;
    logic                 alusrc_e_q, regw_e_q, memw_e_q, memtoreg_e_q, branch_e_q, pcs_e_q;
    logic [1:0]           flagw_e_q;
    logic [3:0]           cond_e_q;

    // D->E register; a flush loads a write-free bubble with an AL condition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_e_q      <= '0;
            alusrc_e_q   <= 1'b0;
            regw_e_q     <= 1'b0;
            memw_e_q     <= 1'b0;
            memtoreg_e_q <= 1'b0;
            branch_e_q   <= 1'b0;
            pcs_e_q      <= 1'b0;
            flagw_e_q    <= 2'b00;
            cond_e_q     <= 4'h0;
        end else if (FlushE) begin
            alu_e_q      <= '0;
            alusrc_e_q   <= 1'b0;
            regw_e_q     <= 1'b0;
            memw_e_q     <= 1'b0;
            memtoreg_e_q <= 1'b0;
            branch_e_q   <= 1'b0;
            pcs_e_q      <= 1'b0;
            flagw_e_q    <= 2'b00;
            cond_e_q     <= COND_AL;
        end else begin
            alu_e_q      <= alu_d;
            alusrc_e_q   <= alusrc_d;
            regw_e_q     <= regw_d;
            memw_e_q     <= memw_d;
            memtoreg_e_q <= memtoreg_d;
            branch_e_q   <= branch_d;
            pcs_e_q      <= pcs_d;
            flagw_e_q    <= flagw_d;
            cond_e_q     <= cond_d_w();
        end
    end

    function automatic logic [3:0] cond_d_w();
        return InstrD[31:28];
    endfunction

    logic [3:0] flags_q, flags_d;
    logic       flag_n, flag_z, flag_c, flag_v, cond_ex;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Condition check of the E-stage instruction against the committed flags.
    always_comb begin
        cond_ex = 1'b0;
`ifdef COND_EXEC_EN
        case (cond_e_q)
            4'h0: cond_ex = flag_z;
            4'h1: cond_ex = ~flag_z;
            4'h2: cond_ex = flag_c;
            4'h3: cond_ex = ~flag_c;
            4'h4: cond_ex = flag_n;
            4'h5: cond_ex = ~flag_n;
            4'h6: cond_ex = flag_v;
            4'h7: cond_ex = ~flag_v;
            4'h8: cond_ex = flag_c & ~flag_z;
            4'h9: cond_ex = ~flag_c | flag_z;
            4'hA: cond_ex = (flag_n == flag_v);
            4'hB: cond_ex = (flag_n != flag_v);
            4'hC: cond_ex = ~flag_z & (flag_n == flag_v);
            4'hD: cond_ex = flag_z | (flag_n != flag_v);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
`else
        cond_ex = 1'b1;
`endif
    end

`ifndef COND_EXEC_EN
    logic unused_cond;
    assign unused_cond = ^{cond_e_q, flag_n, flag_z, flag_c, flag_v};
`endif

    // Flag update: NZ and CV groups written independently by the executing instruction.
    always_comb begin
        flags_d = flags_q;
        if (flagw_e_q[1] && cond_ex) flags_d[3:2] = ALUFlagsE[3:2];
        if (flagw_e_q[0] && cond_ex) flags_d[1:0] = ALUFlagsE[1:0];
    end

    // NZCV register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flags_q <= 4'b0000;
        else        flags_q <= flags_d;
    end

    logic regw_m_q, memw_m_q, memtoreg_m_q, pcs_m_q;
    logic regw_w_q, memtoreg_w_q, pcs_w_q;

    // E->M and M->W registers carry the condition-gated enables.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regw_m_q     <= 1'b0;
            memw_m_q     <= 1'b0;
            memtoreg_m_q <= 1'b0;
            pcs_m_q      <= 1'b0;
            regw_w_q     <= 1'b0;
            memtoreg_w_q <= 1'b0;
            pcs_w_q      <= 1'b0;
        end else begin
            regw_m_q     <= regw_e_q & cond_ex;
            memw_m_q     <= memw_e_q & cond_ex;
            memtoreg_m_q <= memtoreg_e_q;
            pcs_m_q      <= pcs_e_q & cond_ex;
            regw_w_q     <= regw_m_q;
            memtoreg_w_q <= memtoreg_m_q;
            pcs_w_q      <= pcs_m_q;
        end
    end

    assign ALUControlE  = alu_e_q;
    assign ALUSrcE      = alusrc_e_q;
    assign MemtoRegE    = memtoreg_e_q;
    assign BranchTakenE = branch_e_q & cond_ex;
    assign RegWriteM    = regw_m_q;
    assign MemWriteM    = memw_m_q;
    assign RegWriteW    = regw_w_q;
    assign MemtoRegW    = memtoreg_w_q;
    assign PCSrcW       = pcs_w_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Testbench for ctrl_pipe_unit: two instances (2-bit ALU control with CMP,
// 3-bit ALU control without CMP) checked against an instruction-level model.
module tb_ctrl_pipe_unit;
    localparam logic [31:0] I_NOP      = 32'hEC000000;
    localparam logic [31:0] I_ADD      = 32'hE0821003;
    localparam logic [31:0] I_CMP      = 32'hE1510001;
    localparam logic [31:0] I_BEQ      = 32'h0A000002;
    localparam logic [31:0] I_BNE      = 32'h1A000002;
    localparam logic [31:0] I_STR      = 32'hE5812000;
    localparam logic [31:0] I_ADDS_PC  = 32'hE09FF001;
    localparam logic [31:0] I_ADDEQ_PC = 32'h008FF001;
    localparam logic [31:0] I_EOR      = 32'hE0210002;

    logic        clk, reset, FlushE;
    logic [31:0] InstrD;
    logic [3:0]  ALUFlagsE;

    logic [1:0] alu_c2, imm2, rsrc2;
    logic [2:0] alu_c3;
    logic [1:0] imm3, rsrc3;
    logic alusrc2, bt2, pcs2, rwm2, rww2, mwm2, mre2, mrw2;
    logic alusrc3, bt3, pcs3, rwm3, rww3, mwm3, mre3, mrw3;

    int n_checks = 0;
    int n_pass   = 0;

    ctrl_pipe_unit #(.ALUCTRL_W(2), .CMP_EN_CMD(1'b1)) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .FlushE(FlushE), .ALUFlagsE(ALUFlagsE),
        .ALUControlE(alu_c2), .ALUSrcE(alusrc2), .ImmSrcD(imm2), .RegSrcD(rsrc2),
        .BranchTakenE(bt2), .PCSrcW(pcs2), .RegWriteM(rwm2), .RegWriteW(rww2),
        .MemWriteM(mwm2), .MemtoRegE(mre2), .MemtoRegW(mrw2));

    ctrl_pipe_unit #(.ALUCTRL_W(3), .CMP_EN_CMD(1'b0)) dut3 (
        .clk(clk), .reset(reset), .InstrD(InstrD), .FlushE(FlushE), .ALUFlagsE(ALUFlagsE),
        .ALUControlE(alu_c3), .ALUSrcE(alusrc3), .ImmSrcD(imm3), .RegSrcD(rsrc3),
        .BranchTakenE(bt3), .PCSrcW(pcs3), .RegWriteM(rwm3), .RegWriteW(rww3),
        .MemWriteM(mwm3), .MemtoRegE(mre3), .MemtoRegW(mrw3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum int {K_NOP, K_ADD, K_SUB, K_AND, K_ORR, K_EOR, K_CMP, K_LDR, K_STR, K_B} kind_t;

    typedef struct packed {
        logic [3:0] cond;
        logic [2:0] alu;
        logic       alusrc, regw, memw, memtoreg, branch, pcs;
        logic [1:0] flagw, imm, rsrc;
    } ctl_t;

    typedef struct packed {
        logic regw, memw, memtoreg, pcs;
    } stg_t;

    ctl_t       se [2];
    stg_t       sm [2];
    stg_t       sw [2];
    logic [3:0] fl [2];

    function automatic kind_t kind_of(input logic [31:0] ins, input int w, input bit cmp_en);
        logic [3:0] cmd;
        cmd = ins[24:21];
        if (ins[27:26] == 2'd1) return ins[20] ? K_LDR : K_STR;
        if (ins[27:26] == 2'd2) return K_B;
        if (ins[27:26] == 2'd3) return K_NOP;
        case (cmd)
            4'd4:  return K_ADD;
            4'd2:  return K_SUB;
            4'd0:  return K_AND;
            4'd12: return K_ORR;
            4'd1:  return (w >= 3) ? K_EOR : K_NOP;
            4'd10: return (cmp_en && ins[20]) ? K_CMP : K_NOP;
            default: return K_NOP;
        endcase
    endfunction

    function automatic ctl_t decode_ref(input logic [31:0] ins, input int w, input bit cmp_en);
        ctl_t  c;
        kind_t k;
        logic  s;
        c = '0;
        k = kind_of(ins, w, cmp_en);
        s = ins[20];
        c.cond = ins[31:28];
        case (k)
            K_ADD: begin c.alu = 3'd0; c.regw = 1'b1; c.flagw = {s, s};    end
            K_SUB: begin c.alu = 3'd1; c.regw = 1'b1; c.flagw = {s, s};    end
            K_AND: begin c.alu = 3'd2; c.regw = 1'b1; c.flagw = {s, 1'b0}; end
            K_ORR: begin c.alu = 3'd3; c.regw = 1'b1; c.flagw = {s, 1'b0}; end
            K_EOR: begin c.alu = 3'd4; c.regw = 1'b1; c.flagw = {s, 1'b0}; end
            K_CMP: begin c.alu = 3'd1; c.flagw = 2'b11; end
            K_LDR: begin c.regw = 1'b1; c.memtoreg = 1'b1; c.alusrc = 1'b1; c.imm = 2'd1; end
            K_STR: begin c.memw = 1'b1; c.alusrc = 1'b1; c.imm = 2'd1; c.rsrc = 2'b10; end
            K_B:   begin c.branch = 1'b1; c.alusrc = 1'b1; c.imm = 2'd2; c.rsrc = 2'b01; end
            default: ;
        endcase
        if (k inside {K_ADD, K_SUB, K_AND, K_ORR, K_EOR, K_CMP}) c.alusrc = ins[25];
        c.pcs = (c.regw && (ins[15:12] == 4'hF)) || c.branch;
        return c;
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (c)
            4'h0: r = z;             4'h1: r = !z;
            4'h2: r = cf;            4'h3: r = !cf;
            4'h4: r = n;             4'h5: r = !n;
            4'h6: r = v;             4'h7: r = !v;
            4'h8: r = cf && !z;      4'h9: r = !cf || z;
            4'hA: r = (n == v);      4'hB: r = (n != v);
            4'hC: r = !z && (n == v); 4'hD: r = z || (n != v);
            4'hE: r = 1'b1;
            default: r = 1'b0;
        endcase
`ifndef COND_EXEC_EN
        r = 1'b1;
`endif
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            se[i] = '0;
            sm[i] = '0;
            sw[i] = '0;
            fl[i] = 4'h0;
        end
    endfunction

    function automatic void model_edge(input logic flush, input logic [31:0] ins, input logic [3:0] af);
        for (int i = 0; i < 2; i++) begin
            logic ce;
            ce = cond_ok(se[i].cond, fl[i]);
            if (se[i].flagw[1] && ce) fl[i][3:2] = af[3:2];
            if (se[i].flagw[0] && ce) fl[i][1:0] = af[1:0];
            sw[i] = sm[i];
            sm[i] = '{regw: se[i].regw && ce, memw: se[i].memw && ce,
                      memtoreg: se[i].memtoreg, pcs: se[i].pcs && ce};
            if (flush) begin
                se[i] = '0;
                se[i].cond = 4'hE;
            end else begin
                se[i] = decode_ref(ins, (i == 0) ? 2 : 3, (i == 0));
            end
        end
    endfunction

    function automatic logic [18:0] exp_vec(input int i);
        ctl_t d;
        d = decode_ref(InstrD, (i == 0) ? 2 : 3, (i == 0));
        return {(i == 0) ? {1'b0, se[i].alu[1:0]} : se[i].alu, se[i].alusrc,
                se[i].branch && cond_ok(se[i].cond, fl[i]), sw[i].pcs, sm[i].regw, sw[i].regw,
                sm[i].memw, se[i].memtoreg, sw[i].memtoreg, d.imm, d.rsrc, fl[i]};
    endfunction

    function automatic logic [18:0] obs_vec(input int i);
        if (i == 0)
            return {1'b0, alu_c2, alusrc2, bt2, pcs2, rwm2, rww2, mwm2, mre2, mrw2, imm2, rsrc2, dut.flags_q};
        return {alu_c3, alusrc3, bt3, pcs3, rwm3, rww3, mwm3, mre3, mrw3, imm3, rsrc3, dut3.flags_q};
    endfunction

    // One clock: drive inputs after the falling edge, sample at the next falling edge.
    task automatic step(input logic [31:0] ins, input logic flush, input logic [3:0] af);
        InstrD    = ins;
        FlushE    = flush;
        ALUFlagsE = af;
        @(posedge clk);
        model_edge(flush, ins, af);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [9:0] ewm;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        ewm = {alu_c2, alusrc2, bt2, pcs2, rwm2, rww2, mwm2, mre2, mrw2};
        n_checks++;
        if (ewm !== 10'd0) $display("FAIL reset_outs dut got %h expected 0", ewm);
        else n_pass++;
        n_checks++;
        if ({alu_c3, rwm3, rww3, mwm3, pcs3, bt3} !== 8'd0)
            $display("FAIL reset_outs dut3 got %h expected 0", {alu_c3, rwm3, rww3, mwm3, pcs3, bt3});
        else n_pass++;
        n_checks++;
        if (dut.flags_q !== 4'b0000) $display("FAIL reset_flags got %b expected 0000", dut.flags_q);
        else n_pass++;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_add();
        step(I_ADD, 1'b0, 4'h0);
        n_checks++;
        if ({alu_c2, alusrc2, rwm2} !== 4'b0000) $display("FAIL add_e got %b expected 0000", {alu_c2, alusrc2, rwm2});
        else n_pass++;
        step(I_NOP, 1'b0, 4'h0);
        n_checks++;
        if (rwm2 !== 1'b1) $display("FAIL add_regwrite_m got %b expected 1", rwm2);
        else n_pass++;
        step(I_NOP, 1'b0, 4'h0);
        n_checks++;
        if ({rww2, pcs2} !== 2'b10) $display("FAIL add_w got %b expected 10", {rww2, pcs2});
        else n_pass++;
    endtask

    task automatic test_cmp_branch();
        logic exp_bne;
        step(I_CMP, 1'b0, 4'h0);
        n_checks++;
        if ({alu_c2, rwm2} !== 3'b010) $display("FAIL cmp_e got %b expected 010", {alu_c2, rwm2});
        else n_pass++;
        step(I_BEQ, 1'b0, 4'b0100);
        n_checks++;
        if (dut.flags_q !== 4'b0100) $display("FAIL cmp_flags got %b expected 0100", dut.flags_q);
        else n_pass++;
        n_checks++;
        if (bt2 !== 1'b1) $display("FAIL beq_taken got %b expected 1", bt2);
        else n_pass++;
        n_checks++;
        if (rwm2 !== 1'b0) $display("FAIL cmp_no_regwrite got %b expected 0", rwm2);
        else n_pass++;
        step(I_CMP, 1'b0, 4'h0);
        step(I_BNE, 1'b0, 4'b0100);
`ifdef COND_EXEC_EN
        exp_bne = 1'b0;
`else
        exp_bne = 1'b1;
`endif
        n_checks++;
        if (bt2 !== exp_bne) $display("FAIL bne_taken got %b expected %b", bt2, exp_bne);
        else n_pass++;
    endtask

    task automatic test_flush();
        step(I_NOP, 1'b0, 4'hF);
        step(I_STR, 1'b1, 4'hF);
        n_checks++;
        if ({alusrc2, mre2, bt2} !== 3'b000) $display("FAIL flush_e got %b expected 000", {alusrc2, mre2, bt2});
        else n_pass++;
        step(I_CMP, 1'b1, 4'hF);
        n_checks++;
        if (mwm2 !== 1'b0) $display("FAIL flush_memwrite got %b expected 0", mwm2);
        else n_pass++;
        step(I_NOP, 1'b0, 4'hF);
        n_checks++;
        if (dut.flags_q !== 4'b0100) $display("FAIL flush_flags got %b expected 0100", dut.flags_q);
        else n_pass++;
    endtask

    task automatic test_pc_write();
        logic exp_pc;
        step(I_ADDS_PC, 1'b0, 4'h0);
        step(I_NOP, 1'b0, 4'h0);
        step(I_NOP, 1'b0, 4'h0);
        n_checks++;
        if ({pcs2, rww2} !== 2'b11) $display("FAIL adds_pc_w got %b expected 11", {pcs2, rww2});
        else n_pass++;
        n_checks++;
        if (dut.flags_q !== 4'b0000) $display("FAIL adds_flags got %b expected 0000", dut.flags_q);
        else n_pass++;
        step(I_ADDEQ_PC, 1'b0, 4'hF);
        step(I_NOP, 1'b0, 4'hF);
        step(I_NOP, 1'b0, 4'hF);
`ifdef COND_EXEC_EN
        exp_pc = 1'b0;
`else
        exp_pc = 1'b1;
`endif
        n_checks++;
        if (pcs2 !== exp_pc) $display("FAIL addeq_pc_w got %b expected %b", pcs2, exp_pc);
        else n_pass++;
    endtask

    task automatic test_eor_and_reset();
        step(I_EOR, 1'b0, 4'h0);
        n_checks++;
        if ({alu_c3, alu_c2} !== 5'b100_00) $display("FAIL eor_alu got %b expected 10000", {alu_c3, alu_c2});
        else n_pass++;
        step(I_NOP, 1'b0, 4'h0);
        step(I_NOP, 1'b0, 4'h0);
        n_checks++;
        if ({rww3, rww2} !== 2'b10) $display("FAIL eor_regwrite_w got %b expected 10", {rww3, rww2});
        else n_pass++;
        step(I_ADD, 1'b0, 4'h0);
        step(I_ADD, 1'b0, 4'h0);
        step(I_NOP, 1'b0, 4'h0);
        n_checks++;
        if ({rwm2, rww2} !== 2'b11) $display("FAIL pre_reset_mw got %b expected 11", {rwm2, rww2});
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({rwm2, rww2, mwm2, pcs2, bt2, rwm3, rww3} !== 7'd0)
            $display("FAIL midreset_writes got %b expected 0", {rwm2, rww2, mwm2, pcs2, bt2, rwm3, rww3});
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [3:0]  af;
        logic        fl_in;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            ins = $urandom;
            case ($urandom_range(0, 6))
                0, 1, 2: begin
                    ins[27:26] = 2'd0;
                    case ($urandom_range(0, 6))
                        0: ins[24:21] = 4'd4;
                        1: ins[24:21] = 4'd2;
                        2: ins[24:21] = 4'd0;
                        3: ins[24:21] = 4'd12;
                        4: ins[24:21] = 4'd1;
                        5: ins[24:21] = 4'd10;
                        default: ;
                    endcase
                    if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
                end
                3: ins[27:26] = 2'd1;
                4: ins[27:26] = 2'd2;
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0) ins[31:28] = 4'hE;
            af    = 4'($urandom);
            fl_in = ($urandom_range(0, 7) == 0);
            step(ins, fl_in, af);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i))
                    $display("FAIL random[%0d] dut%0d instr=%h got %h expected %h",
                             cyc, i, ins, obs_vec(i), exp_vec(i));
                else n_pass++;
            end
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                #1;
                n_checks++;
                if ({rwm2, rww2, mwm2, pcs2, bt2, rwm3, rww3, mwm3, pcs3, bt3} !== 10'd0)
                    $display("FAIL random_reset[%0d] got %b expected 0", cyc,
                             {rwm2, rww2, mwm2, pcs2, bt2, rwm3, rww3, mwm3, pcs3, bt3});
                else n_pass++;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b1;
                model_reset();
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        InstrD    = I_NOP;
        FlushE    = 1'b0;
        ALUFlagsE = 4'h0;
        model_reset();
        test_reset();
        test_add();
        test_cmp_branch();
        test_flush();
        test_pc_write();
        test_eor_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
